// File: rtl/phase_a_sched.sv
// Round-robin scheduler sharing one phase_a datapath between two requesters,
// iterating each operand ITER times. Optional watchdog: PHASE_A_SCHED_WATCHDOG_EN.
module phase_a_sched #(
  parameter int unsigned SIZE    = 3072,
  parameter int unsigned ITER    = 40,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [SIZE-1:0] req_a0,
  input  logic [SIZE-1:0] req_a1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_data,
  output logic            rsp_err,
  output logic            busy,
  output logic            pa_en,
  output logic [SIZE-1:0] pa_a,
  input  logic [SIZE-1:0] pa_new_a,
  input  logic            pa_en_out
);

  localparam int unsigned IW = $clog2(ITER + 1);

  if (ITER < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("phase_a_sched: ITER and TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  logic [SIZE-1:0] op_q, op_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            busy_q, busy_d;
  logic            pa_en_q, pa_en_d;
  logic [1:0]      grant;

`ifdef PHASE_A_SCHED_WATCHDOG_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          wd_hit;
  logic          rsp_err_q, rsp_err_d;
`endif

  // The requester not granted last time has priority when both are valid.
  always_comb begin
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = (state_q == S_IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      op_q        <= '0;
      iter_q      <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      pa_en_q     <= 1'b0;
`ifdef PHASE_A_SCHED_WATCHDOG_EN
      wd_q        <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      op_q        <= op_d;
      iter_q      <= iter_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      pa_en_q     <= pa_en_d;
`ifdef PHASE_A_SCHED_WATCHDOG_EN
      wd_q        <= wd_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    iter_d  = iter_q;
`ifdef PHASE_A_SCHED_WATCHDOG_EN
    wd_d    = wd_q;
    wd_hit  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|grant) begin
          op_d    = grant[1] ? req_a1 : req_a0;
          id_d    = grant[1];
          last_d  = grant[1];
          iter_d  = IW'(ITER);
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef PHASE_A_SCHED_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        if (pa_en_out) begin
          op_d    = pa_new_a;
          iter_d  = iter_q - IW'(1);
          state_d = (iter_q == IW'(1)) ? S_RESP : S_LAUNCH;
        end
`ifdef PHASE_A_SCHED_WATCHDOG_EN
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          wd_hit  = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d    = wd_q + WW'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
    pa_en_d     = (state_d == S_LAUNCH);
`ifdef PHASE_A_SCHED_WATCHDOG_EN
    if (state_d != S_RESP)      rsp_err_d = 1'b0;
    else if (state_q == S_RESP) rsp_err_d = rsp_err_q;
    else                        rsp_err_d = wd_hit;
`endif
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = op_q;
  assign busy      = busy_q;
  assign pa_en     = pa_en_q;
  assign pa_a      = op_q;
`ifdef PHASE_A_SCHED_WATCHDOG_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_phase_a_sched.sv
// Directed bench for phase_a_sched with a stub datapath (new_a = a+1, L=19).
module tb_phase_a_sched;
  localparam int unsigned SIZE = 64, ITER = 40, TIMEOUT = 64, L = 19;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic [1:0]      req_valid = '0, req_ready;
  logic [SIZE-1:0] req_a0 = '0, req_a1 = '0;
  logic            rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err, busy, pa_en;
  logic [SIZE-1:0] rsp_data, pa_a;
  logic [SIZE-1:0] pa_new_a = '0;
  logic            pa_en_out;

  phase_a_sched #(.SIZE(SIZE), .ITER(ITER), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .pa_en(pa_en), .pa_a(pa_a), .pa_new_a(pa_new_a), .pa_en_out(pa_en_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub datapath: done strobe L cycles after the pa_en-high cycle.
  logic        stall = 1'b0, stray = 1'b0, stub_out = 1'b0, pa_en_prev = 1'b0;
  int unsigned scnt = 0;
  always @(posedge clk) begin
    pa_en_prev <= pa_en;
    stub_out   <= (scnt == 1) && !stall;
    if (scnt == 1) pa_new_a <= pa_a + 1;
    if (pa_en && !pa_en_prev) scnt <= L - 1;
    else if (scnt != 0)       scnt <= scnt - 1;
  end
  assign pa_en_out = stub_out | stray;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [1:0]      valid;
    logic [SIZE-1:0] a0, a1;
    logic            exp_id;
    logic [SIZE-1:0] exp_data;
    int unsigned     hold;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int   t_acc, waited, npulse;
    logic prev, dbl, stable;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = v.valid; req_a0 = v.a0; req_a1 = v.a1;
    #1;
    waited = 0;
    while (!(|(req_ready & req_valid)) && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    chk("accept_prompt", waited, 0);
    chk("grant_onehot", req_ready, v.exp_id ? 2'b10 : 2'b01);
    t_acc = cyc;
    @(negedge clk);
    req_valid = '0; npulse = 0; prev = 1'b0; dbl = 1'b0; waited = 0;
    while (!rsp_valid && waited < 3000) begin
      if (pa_en) npulse++;
      if (pa_en && prev) dbl = 1'b1;
      prev = pa_en;
      @(negedge clk); waited++;
    end
    chk("rsp_latency", cyc - t_acc, ITER * (L + 1) + 1);
    chk("pa_en_pulses", npulse, ITER);
    chk("pa_en_width1", dbl, 0);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_id", rsp_id, v.exp_id);
    chk("rsp_err", rsp_err, 0);
    if (v.hold > 0) begin
      stable = 1'b1;
      req_valid = 2'b11;
      for (int unsigned i = 0; i < v.hold; i++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== v.exp_data || rsp_id !== v.exp_id ||
            req_ready !== 2'b00 || busy !== 1'b1) stable = 1'b0;
      end
      chk("rsp_hold_stable", stable, 1);
      @(negedge clk);
      req_valid = '0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", {rsp_valid, busy}, 2'b00);
  endtask

  vec_t tbl[6];

  initial begin
    int cnt, waited;
    tbl[0] = '{2'b01, 64'h100, 64'h0,   1'b0, 64'h128, 0};
    tbl[1] = '{2'b11, 64'h200, 64'h300, 1'b1, 64'h328, 1};
    tbl[2] = '{2'b11, 64'h400, 64'h500, 1'b0, 64'h428, 50};
    tbl[3] = '{2'b11, 64'h600, 64'h700, 1'b1, 64'h728, 0};
    tbl[4] = '{2'b10, 64'h0,   64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h18, 2};
    tbl[5] = '{2'b11, 64'h800, 64'h900, 1'b0, 64'h828, 0};

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {req_ready, rsp_valid, rsp_id, rsp_err, busy, pa_en}, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_pa_a", pa_a, 0);
    rst_n = 1'b1;

    // Stray done strobe while idle must not disturb anything.
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    chk("stray_idle", {busy, rsp_valid}, 2'b00);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Reset during the tenth iteration, then a fresh request.
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 2'b01; req_a0 = 64'h1000;
    #1;
    waited = 0;
    while (!req_ready[0] && waited < 20) begin @(negedge clk); #1; waited++; end
    chk("mid_accept", waited, 0);
    @(negedge clk);
    req_valid = '0; cnt = 0; waited = 0;
    while (cnt < 10 && waited < 1000) begin
      if (pa_en) cnt++;
      if (cnt < 10) @(negedge clk);
      waited++;
    end
    chk("mid_iter10", cnt, 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {req_ready, rsp_valid, rsp_id, rsp_err, busy, pa_en}, 0);
    chk("abort_data", rsp_data, 0);
    chk("abort_pa_a", pa_a, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_vec('{2'b11, 64'h2000, 64'h3000, 1'b0, 64'h2028, 0});

    // Stalled datapath.
    stall = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 2'b01; req_a0 = 64'h5000;
    #1;
    chk("stall_accept", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
`ifdef PHASE_A_SCHED_WATCHDOG_EN
    waited = 0;
    while (!rsp_valid && waited < 500) begin @(negedge clk); waited++; end
    chk("wd_rsp_valid", rsp_valid, 1);
    chk("wd_rsp_err", rsp_err, 1);
    chk("wd_rsp_data", rsp_data, 64'h5000);
    chk("wd_rsp_id", rsp_id, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("wd_err_clear", {rsp_err, rsp_valid, busy}, 3'b000);
`else
    repeat (200) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_no_rsp", {rsp_valid, rsp_err}, 2'b00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/phase_a_sched.md
# phase_a_sched

Round-robin scheduler that shares one `phase_a` reduction datapath between two requesters. It also iterates each accepted operand through the datapath `ITER` times, feeding `new_a` back as the next `a`. It sits between the modular-multiplication front ends and the `phase_a` instance. It owns the datapath's `en`/`a` inputs and the `new_a`/`en_out` outputs. `m`, `m_n` and `m_prime` are driven statically from the top level and do not pass through this block.

## Interface
Parameters:
- `SIZE`, 3072: operand width.
- `ITER`, 40: datapath passes per request, ceil(SIZE/78). Must be ≥1.
- `TIMEOUT`, 64: watchdog limit in cycles; only used with the macro.

Ports:
- `clk` in, 1: clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `req_valid` in, 2: per-requester request valid.
- `req_ready` out, 2: per-requester accept, one-hot or zero.
- `req_a0` in, SIZE: requester 0 operand.
- `req_a1` in, SIZE: requester 1 operand.
- `rsp_valid` out, 1: result valid.
- `rsp_ready` in, 1: result consumed.
- `rsp_id` out, 1: requester that owns the result.
- `rsp_data` out, SIZE: result operand.
- `rsp_err` out, 1: watchdog abort flag. Tied to 0 without the macro.
- `busy` out, 1: state is not IDLE.
- `pa_en` out, 1: datapath enable. Pulsed for exactly one cycle.
- `pa_a` out, SIZE: datapath operand. Held stable from launch through `pa_en_out`.
- `pa_new_a` in, SIZE: datapath result. Valid only in the `pa_en_out` cycle.
- `pa_en_out` in, 1: datapath done strobe.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - `req_ready` is driven to the arbitration winner.
  - Arbitration is round-robin. Pointer `last` holds the id last granted; the other requester has priority.
  - Reset value of `last` is 1, so requester 0 wins first.
  - If only one requester is valid, it wins.
  - On `req_valid & req_ready`: latch the operand into `op_q` and the id into `id_q`, set `iter_q` = ITER, update `last`, go to LAUNCH.
- **LAUNCH**
  - `pa_en`=1 for this single cycle; `pa_a`=`op_q`. Go to WAIT.
- **WAIT**
  - `pa_en`=0.
  - On `pa_en_out`: `op_q` ← `pa_new_a`, `iter_q` ← `iter_q`−1.
  - If the new `iter_q` is nonzero, go to LAUNCH; otherwise go to RESP.
- **RESP**
  - `rsp_valid`=1, with `rsp_data`=`op_q` and `rsp_id`=`id_q` held stable.
  - On `rsp_ready`, go to IDLE. A new request is accepted no earlier than the following cycle.
- `pa_en` must be low for at least one cycle before every rising edge, because the datapath edge-detects `en`. The LAUNCH/WAIT structure guarantees this.
- `pa_en_out` outside WAIT is ignored.
- A request whose `req_valid` drops before acceptance is dropped silently.
- `iter_q` width is clog2(ITER+1).

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `pa_en`=0, `pa_a`=0. State is IDLE and `last`=1.
- Let L be the number of cycles from the `pa_en`-high cycle to the `pa_en_out`-high cycle. L is about 19 for the current datapath; the scheduler never assumes L and always waits for `pa_en_out`.
- Accept at cycle T gives the first launch at T+1. Each iteration lasts L+1 cycles.
- `rsp_valid` first rises at T+ITER·(L+1)+1.
- `req_ready` is combinational from state and `req_valid`. All other outputs are registered.
- Asserting `rst_n` mid-operation aborts immediately to the reset values. The in-flight request is lost, and any `pa_en_out` after reset is ignored.

## Configuration
- Macro `PHASE_A_SCHED_WATCHDOG_EN`.
- **Defined:**
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without `pa_en_out`, go to RESP with `rsp_err`=1. `rsp_data` is the last good `op_q`.
  - `rsp_err` clears on leaving RESP.
- **Undefined:** no counter is built, `rsp_err` is constant 0, and WAIT waits indefinitely.

## Test plan
All scenarios use a stub datapath that returns `new_a` = `a`+1 with L=19.
- Single request: `req_a0`=0x100, ITER=40, accepted at T → `rsp_valid` at T+801 with `rsp_data`=0x128, `rsp_id`=0, `rsp_err`=0, and exactly 40 `pa_en` pulses, each one cycle wide.
- Both requesters valid continuously with `rsp_ready`=1 → grants alternate 0, 1, 0, 1. `req_ready` is never asserted for both in the same cycle.
- `rsp_ready` held 0 for 50 cycles → `rsp_valid`, `rsp_data` and `rsp_id` stay stable and `req_ready` stays 0. The next accept occurs one cycle after the `rsp_ready` handshake.
- Stray `pa_en_out` pulse in IDLE, then a normal request → the stray pulse is ignored and the result is exact (`a`+40).
- `rst_n` dropped at iteration 10 → all outputs go to reset values asynchronously. After release, a fresh request to requester 0 completes correctly.
- With the macro defined and the stub stalled (no `pa_en_out`), TIMEOUT=64 → `rsp_valid`=1 and `rsp_err`=1, with `rsp_data` equal to the last good operand. Without the macro, `busy` stays 1 and `rsp_valid` stays 0.
